// File: rtl/dmem_dump.sv
// dmem_dump: streams data-memory words [base_addr, base_addr+word_cnt) as (addr,data) beats; first mem_rd_en 1 cycle and
// first out_valid 3 cycles after start; out_valid holds under out_ready=0. DMEM_DUMP_CHECKSUM_EN adds a running checksum.
module dmem_dump #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 11
) (
  input  logic              clk_x,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  word_cnt,
  output logic              busy,
  output logic              done,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
`ifdef DMEM_DUMP_CHECKSUM_EN
  output logic [DATA_W-1:0] checksum,
`endif
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_last
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ISSUE   = 3'd1,
    CAPTURE = 3'd2,
    SEND    = 3'd3,
    FINISH  = 3'd4
  } state_t;

  state_t            state, nxt;
  logic [ADDR_W-1:0] cur_addr;
  logic [CNT_W-1:0]  remaining;
  logic              start_ok;
  logic              beat;

  // done is registered off FINISH, so the done cycle is already IDLE; start is held off there
  assign start_ok  = (state == IDLE) && start && !done;
  assign beat      = out_valid && out_ready;
  assign busy      = (state != IDLE);
  assign mem_rd_en = (state == ISSUE);

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (start_ok) nxt = (word_cnt == '0) ? FINISH : ISSUE;
      ISSUE:   nxt = CAPTURE;
      CAPTURE: nxt = SEND;
      SEND:    if (beat) nxt = out_last ? FINISH : ISSUE;
      FINISH:  nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_x or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cur_addr  <= '0;
      remaining <= '0;
      mem_addr  <= '0;
      done      <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_addr  <= '0;
      out_last  <= 1'b0;
    end else begin
      state <= nxt;
      done  <= (state == FINISH);
      if (start_ok) begin
        cur_addr  <= base_addr;
        remaining <= word_cnt;
        if (word_cnt != '0) mem_addr <= base_addr;
      end
      if (state == CAPTURE) begin
        out_data  <= mem_rdata;
        out_addr  <= cur_addr;
        out_last  <= (remaining == CNT_W'(1));
        out_valid <= 1'b1;
      end
      if (beat) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
        remaining <= remaining - CNT_W'(1);
        cur_addr  <= cur_addr + ADDR_W'(1);
        // mem_addr only moves when another read will follow
        if (!out_last) mem_addr <= cur_addr + ADDR_W'(1);
      end
    end
  end

`ifdef DMEM_DUMP_CHECKSUM_EN
  always_ff @(posedge clk_x or negedge rst_n) begin
    if (!rst_n)         checksum <= '0;
    else if (start_ok)  checksum <= '0;
    else if (beat)      checksum <= checksum + out_data;
  end
`endif

endmodule

// File: tb/tb_dmem_dump.sv
// Directed bench for dmem_dump: table of dump vectors plus hand sequences for zero count, busy-start and mid-dump reset.
module tb_dmem_dump;

  logic        clk_x = 1'b0;
  logic        rst_n;
  logic        start;
  logic [9:0]  base_addr;
  logic [10:0] word_cnt;
  logic        busy, done, mem_rd_en;
  logic [9:0]  mem_addr;
  logic [31:0] mem_rdata;
  logic        out_valid, out_ready, out_last;
  logic [31:0] out_data;
  logic [9:0]  out_addr;
`ifdef DMEM_DUMP_CHECKSUM_EN
  logic [31:0] checksum;
`endif

  int total = 0;
  int bad   = 0;

  logic [31:0] mem [1024];

  always #5 clk_x = ~clk_x;

  always_ff @(posedge clk_x) if (mem_rd_en) mem_rdata <= mem[mem_addr];

  dmem_dump #(.ADDR_W(10), .DATA_W(32), .CNT_W(11)) dut (
    .clk_x     (clk_x),
    .rst_n     (rst_n),
    .start     (start),
    .base_addr (base_addr),
    .word_cnt  (word_cnt),
    .busy      (busy),
    .done      (done),
    .mem_rd_en (mem_rd_en),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
`ifdef DMEM_DUMP_CHECKSUM_EN
    .checksum  (checksum),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_addr  (out_addr),
    .out_last  (out_last)
  );

  typedef struct packed {
    logic [9:0]       base;
    logic [10:0]      cnt;
    logic [3:0]       stall;
    logic [2:0][9:0]  a;
    logic [2:0][31:0] d;
    logic [31:0]      sum;
  } vec_t;

  vec_t vecs [4];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_dump(input vec_t v);
    int  c, beats, rds, dones, waitc, first_valid;
    bit  fin;
    logic [31:0] cap_d;
    logic [9:0]  cap_a;
    @(negedge clk_x);
    base_addr = v.base; word_cnt = v.cnt; start = 1'b1; out_ready = (v.stall == 0);
    @(negedge clk_x);
    start = 1'b0; c = 1;
    chk("first_rd_en", mem_rd_en, 1);
    chk("first_mem_addr", mem_addr, v.base);
    beats = 0; rds = 0; dones = 0; waitc = 0; fin = 0; first_valid = -1;
    cap_d = '0; cap_a = '0;
    while (!fin && c < 200) begin
      if (mem_rd_en) rds++;
      if (out_valid) begin
        if (first_valid < 0) first_valid = c;
        if (waitc == 0) begin
          cap_d = out_data; cap_a = out_addr;
        end else begin
          chk("stall_data", out_data, cap_d);
          chk("stall_addr", out_addr, cap_a);
        end
        if (waitc < int'(v.stall)) begin
          out_ready = 1'b0; waitc++;
        end else begin
          out_ready = 1'b1;
          if (beats < 3) begin
            chk("beat_addr", out_addr, v.a[beats]);
            chk("beat_data", out_data, v.d[beats]);
          end
          chk("beat_last", out_last, (beats == int'(v.cnt) - 1));
          chk("beat_busy", busy, 1);
          beats++; waitc = 0;
        end
      end
      if (done) begin
        dones++; fin = 1;
        chk("done_busy", busy, 0);
`ifdef DMEM_DUMP_CHECKSUM_EN
        chk("checksum", checksum, v.sum);
`endif
      end
      if (!fin) begin
        @(negedge clk_x); c++;
      end
    end
    chk("dump_timeout", fin, 1);
    chk("beat_count", beats, v.cnt);
    chk("rd_count", rds, v.cnt);
    chk("first_valid_lat", first_valid, 3);
    @(negedge clk_x);
    chk("done_single", done, 0);
  endtask

  initial begin
    int rds, vs, dones;
    vecs[0] = '{base:10'd1, cnt:11'd3, stall:4'd0, a:{10'd3, 10'd2, 10'd1},
                d:{32'h8484D609, 32'hC0895E81, 32'h12153524}, sum:32'h572369AE};
    vecs[1] = '{base:10'd1, cnt:11'd3, stall:4'd4, a:{10'd3, 10'd2, 10'd1},
                d:{32'h8484D609, 32'hC0895E81, 32'h12153524}, sum:32'h572369AE};
    vecs[2] = '{base:10'd1022, cnt:11'd3, stall:4'd0, a:{10'd0, 10'd1023, 10'd1022},
                d:{32'h1000000F, 32'h00000F00, 32'h000000F0}, sum:32'h10000FFF};
    vecs[3] = '{base:10'd1023, cnt:11'd1, stall:4'd2, a:{10'd0, 10'd0, 10'd1023},
                d:{32'h0, 32'h0, 32'h00000F00}, sum:32'h00000F00};
    for (int i = 0; i < 1024; i++) mem[i] = 32'hDEAD0000 | i;
    mem[1] = 32'h12153524; mem[2] = 32'hC0895E81; mem[3] = 32'h8484D609;
    mem[1022] = 32'h000000F0; mem[1023] = 32'h00000F00; mem[0] = 32'h1000000F;

    rst_n = 1'b0; start = 1'b0; base_addr = '0; word_cnt = '0; out_ready = 1'b0;
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rd_en", mem_rd_en, 0);
    chk("rst_outs", {out_valid, out_last, out_addr, out_data, mem_addr}, '0);
    @(negedge clk_x); rst_n = 1'b1;

    for (int i = 0; i < 4; i++) run_dump(vecs[i]);

    // zero-count dump: done two cycles after start, nothing read or sent
    @(negedge clk_x);
    base_addr = 10'd5; word_cnt = 11'd0; start = 1'b1; out_ready = 1'b1;
    rds = 0; vs = 0;
    @(negedge clk_x); start = 1'b0;
    chk("zero_busy", busy, 1);
    chk("zero_done_early", done, 0);
    if (mem_rd_en) rds++;
    if (out_valid) vs++;
    @(negedge clk_x);
    chk("zero_done", done, 1);
    if (mem_rd_en) rds++;
    if (out_valid) vs++;
    @(negedge clk_x);
    chk("zero_rd", rds, 0);
    chk("zero_valid", vs, 0);

    // busy start ignored, then reset during the second SEND
    @(negedge clk_x);
    base_addr = 10'd1; word_cnt = 11'd3; start = 1'b1; out_ready = 1'b1;
    @(negedge clk_x); start = 1'b0;
    repeat (2) @(negedge clk_x);
    chk("rst_seq_beat1", {out_valid, out_addr}, {1'b1, 10'd1});
    @(negedge clk_x);
    out_ready = 1'b0;
    base_addr = 10'd500; word_cnt = 11'd7; start = 1'b1;
    @(negedge clk_x); start = 1'b0;
    @(negedge clk_x);
    chk("busy_start_addr", {out_valid, out_addr}, {1'b1, 10'd2});
    chk("busy_start_data", out_data, 32'hC0895E81);
    rst_n = 1'b0;
    #1;
    chk("midrst_outs", {busy, done, mem_rd_en, out_valid, out_last, out_addr, out_data, mem_addr}, '0);
    @(negedge clk_x); rst_n = 1'b1; out_ready = 1'b1;
    rds = 0; dones = 0;
    repeat (6) begin
      @(negedge clk_x);
      if (mem_rd_en) rds++;
      if (done) dones++;
    end
    chk("post_rst_rd", rds, 0);
    chk("post_rst_done", dones, 0);
    run_dump(vecs[0]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
